// File: rtl/dh_key_gen_pkg.sv
// Shared definitions for the Diffie-Hellman key generator: key/counter widths,
// FSM state type and a modulus-validity helper.
package dh_pkg;

  localparam int KEY_W = 4;
  localparam int CNT_W = 2;

  localparam logic [KEY_W-1:0] ONE = 4'd1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    CALC   = 2'd1,
    FINISH = 2'd2
  } state_t;

  // A modulus of 0 or 1 cannot define a useful residue ring.
  function automatic logic mod_invalid(input logic [KEY_W-1:0] m);
    return (m[KEY_W-1:1] == '0);
  endfunction

endpackage

// File: rtl/dh_key_gen_if.sv
// Request/result bundle between a key-generation client (master) and
// dh_key_gen (slave).
interface dh_key_gen_if;
  import dh_pkg::*;

  logic             start;
  logic [KEY_W-1:0] base_i;
  logic [KEY_W-1:0] exp_i;
  logic [KEY_W-1:0] mod_i;
  logic [KEY_W-1:0] key_o;
  logic             busy;
  logic             done;
  logic             err;

  modport master (
    output start, base_i, exp_i, mod_i,
    input  key_o, busy, done, err
  );

  modport slave (
    input  start, base_i, exp_i, mod_i,
    output key_o, busy, done, err
  );

endinterface

// File: rtl/dh_key_gen_mod_mul.sv
// Combinational modular multiplier: r = (a*b) mod m using a full double-width
// product, so nothing is lost before the reduction. Returns 0 for m < 2.
module dh_mod_mul
  import dh_pkg::*;
(
  input  logic [KEY_W-1:0] a_i,
  input  logic [KEY_W-1:0] b_i,
  input  logic [KEY_W-1:0] m_i,
  output logic [KEY_W-1:0] r_o
);

  logic [2*KEY_W-1:0] prod_w;
  logic [2*KEY_W-1:0] mod_w;

  assign prod_w = {{KEY_W{1'b0}}, a_i} * {{KEY_W{1'b0}}, b_i};
  assign mod_w  = {{KEY_W{1'b0}}, m_i};

  // Reduce the full product; the remainder always fits in KEY_W bits.
  always_comb begin
    r_o = '0;
    if (!mod_invalid(m_i)) begin
      r_o = KEY_W'(prod_w % mod_w);
    end
  end

endmodule

// File: rtl/dh_key_gen.sv
// Diffie-Hellman key generator: key = base^exp mod p by right-to-left
// square-and-multiply, one exponent bit per CALC cycle.
// Optional build macro DH_KEY_EARLY_EXIT_EN: leave CALC as soon as the
// remaining exponent bits are all zero (variable latency, same key).
module dh_key_gen
  import dh_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  dh_key_gen_if.slave bus
);

  state_t           state_q, state_d;
  logic [KEY_W-1:0] acc_q, acc_d;
  logic [KEY_W-1:0] b_q, b_d;
  logic [KEY_W-1:0] exp_q, exp_d;
  logic [KEY_W-1:0] p_q, p_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [KEY_W-1:0] key_q, key_d;
  logic             done_q, done_d;
  logic             err_q, err_d;

  logic [KEY_W-1:0] mul_r;
  logic [KEY_W-1:0] sq_a, sq_b, sq_m, sq_r;
  logic             calc_last;

  // Multiply path: acc * b mod p.
  dh_mod_mul u_mul (
    .a_i (acc_q),
    .b_i (b_q),
    .m_i (p_q),
    .r_o (mul_r)
  );

  // Square path; while idle it is borrowed to reduce the incoming base (base*1 mod p).
  assign sq_a = (state_q == IDLE) ? bus.base_i : b_q;
  assign sq_b = (state_q == IDLE) ? ONE        : b_q;
  assign sq_m = (state_q == IDLE) ? bus.mod_i  : p_q;

  dh_mod_mul u_sqr (
    .a_i (sq_a),
    .b_i (sq_b),
    .m_i (sq_m),
    .r_o (sq_r)
  );

`ifdef DH_KEY_EARLY_EXIT_EN
  logic [KEY_W-1:0] exp_rem;
  // Bits still to be consumed after the current one.
  assign exp_rem   = exp_q >> ({1'b0, cnt_q} + 3'd1);
  assign calc_last = (exp_rem == '0);
`else
  assign calc_last = (cnt_q == CNT_W'(KEY_W - 1));
`endif

  // Next-state and datapath update for the IDLE/CALC/FINISH sequence.
  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    b_d     = b_q;
    exp_d   = exp_q;
    p_d     = p_q;
    cnt_d   = cnt_q;
    key_d   = key_q;
    done_d  = 1'b0;
    err_d   = err_q;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          exp_d   = bus.exp_i;
          p_d     = bus.mod_i;
          b_d     = sq_r;
          acc_d   = ONE;
          cnt_d   = '0;
          err_d   = 1'b0;
          state_d = mod_invalid(bus.mod_i) ? FINISH : CALC;
        end
      end
      CALC: begin
        if (exp_q[cnt_q]) begin
          acc_d = mul_r;
        end
        b_d   = sq_r;
        cnt_d = cnt_q + CNT_W'(1);
        if (calc_last) begin
          state_d = FINISH;
        end
      end
      FINISH: begin
        key_d   = mod_invalid(p_q) ? '0 : acc_q;
        err_d   = mod_invalid(p_q);
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers; reset clears everything and aborts any run.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      acc_q   <= '0;
      b_q     <= '0;
      exp_q   <= '0;
      p_q     <= '0;
      cnt_q   <= '0;
      key_q   <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      b_q     <= b_d;
      exp_q   <= exp_d;
      p_q     <= p_d;
      cnt_q   <= cnt_d;
      key_q   <= key_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  assign bus.key_o = key_q;
  assign bus.done  = done_q;
  assign bus.err   = err_q;
  assign bus.busy  = (state_q != IDLE);

endmodule

// File: tb/tb_dh_key_gen.sv
// Self-checking bench for dh_key_gen: directed scenarios, randomized
// back-to-back runs and a full base/exp/mod sweep against a plain-arithmetic
// model of modular exponentiation.
module tb_dh_key_gen;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   checks = 0;
  int   errors = 0;

  // Key the bench expects key_o to be holding between runs.
  logic [3:0] model_key = 4'd0;

  dh_key_gen_if bus ();

  dh_key_gen dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // base^exp mod p by repeated multiplication; 0 for a degenerate modulus.
  function automatic int ref_key(input int b, input int e, input int p);
    int r;
    if (p < 2) return 0;
    r = 1;
    for (int i = 0; i < e; i++) r = (r * b) % p;
    return r;
  endfunction

  // Cycle number (start accepted at 0) on which done is sampled high.
  function automatic int ref_lat(input int e, input int p);
    int nb;
    if (p < 2) return 2;
`ifdef DH_KEY_EARLY_EXIT_EN
    nb = 1;
    for (int i = 1; i < 4; i++) if ((e >> i) != 0) nb = i + 1;
    return 2 + nb;
`else
    nb = 4;
    return 2 + nb + (e - e);
`endif
  endfunction

  task automatic run_key(input logic [3:0] b, input logic [3:0] e, input logic [3:0] m,
                         input string tag);
    int         lat;
    int         want_lat;
    logic [3:0] want_key;
    logic       want_err;
    want_lat = ref_lat(int'(e), int'(m));
    want_key = 4'(ref_key(int'(b), int'(e), int'(m)));
    want_err = (m < 4'd2);
    bus.base_i = b;
    bus.exp_i  = e;
    bus.mod_i  = m;
    bus.start  = 1'b1;
    @(posedge clk); #1;
    bus.start  = 1'b0;
    bus.base_i = 4'($urandom);
    bus.exp_i  = 4'($urandom);
    bus.mod_i  = 4'($urandom);
    checks++;
    if (bus.err !== 1'b0) begin
      errors++;
      $display("FAIL %s err_clear_on_start got=%b want=0", tag, bus.err);
    end
    lat = 0;
    for (int n = 1; n <= 12; n++) begin
      @(posedge clk); #1;
      if (bus.done === 1'b1) begin
        lat = n + 1;
        break;
      end
      checks++;
      if (bus.busy !== 1'b1 || bus.key_o !== model_key) begin
        errors++;
        $display("FAIL %s busy_hold cyc=%0d busy=%b key=%0d want busy=1 key=%0d",
                 tag, n, bus.busy, bus.key_o, model_key);
      end
    end
    checks++;
    if (lat != want_lat) begin
      errors++;
      $display("FAIL %s latency b=%0d e=%0d m=%0d got=%0d want=%0d (0=timeout)",
               tag, b, e, m, lat, want_lat);
    end
    if (lat != 0) begin
      model_key = want_key;
      checks++;
      if (bus.key_o !== want_key) begin
        errors++;
        $display("FAIL %s key b=%0d e=%0d m=%0d got=%0d want=%0d", tag, b, e, m, bus.key_o, want_key);
      end
      checks++;
      if (bus.err !== want_err || bus.busy !== 1'b0) begin
        errors++;
        $display("FAIL %s err_busy_at_done b=%0d e=%0d m=%0d err=%b busy=%b want err=%b busy=0",
                 tag, b, e, m, bus.err, bus.busy, want_err);
      end
      @(posedge clk); #1;
      checks++;
      if (bus.done !== 1'b0 || bus.key_o !== want_key || bus.err !== want_err) begin
        errors++;
        $display("FAIL %s after_done done=%b key=%0d err=%b want done=0 key=%0d err=%b",
                 tag, bus.done, bus.key_o, bus.err, want_key, want_err);
      end
    end
  endtask

  task automatic test_reset();
    bus.start  = 1'b1;
    bus.base_i = 4'd3;
    bus.exp_i  = 4'd4;
    bus.mod_i  = 4'd7;
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (bus.key_o !== 4'd0 || bus.done !== 1'b0 || bus.busy !== 1'b0 || bus.err !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs key=%0d done=%b busy=%b err=%b want all 0",
               bus.key_o, bus.done, bus.busy, bus.err);
    end
    bus.start = 1'b0;
    rst = 1'b1;
    model_key = 4'd0;
  endtask

  task automatic test_directed();
    run_key(4'd3,  4'd4,  4'd7,  "req031");
    run_key(4'd5,  4'd3,  4'd11, "req032a");
    run_key(4'd2,  4'd15, 4'd13, "req032b");
    run_key(4'd14, 4'd15, 4'd15, "req032c");
    run_key(4'd9,  4'd0,  4'd7,  "exp_zero");
    run_key(4'd6,  4'd1,  4'd7,  "exp_one");
    run_key(4'd5,  4'd7,  4'd0,  "mod_zero");
    run_key(4'd5,  4'd7,  4'd1,  "mod_one");
    // err must persist while idle until the next accepted start
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (bus.err !== 1'b1 || bus.key_o !== 4'd0) begin
      errors++;
      $display("FAIL err_hold err=%b key=%0d want err=1 key=0", bus.err, bus.key_o);
    end
    run_key(4'd12, 4'd5,  4'd2,  "mod_two");
  endtask

  task automatic test_restart_ignored();
    int dones;
    int first;
    bus.base_i = 4'd3;
    bus.exp_i  = 4'd4;
    bus.mod_i  = 4'd7;
    bus.start  = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    dones = 0;
    first = 0;
    for (int n = 1; n <= 16; n++) begin
      // re-pulse start so it is sampled at cycles 2 and 3, with different operands
      if (n == 1 || n == 2) begin
        bus.start  = 1'b1;
        bus.base_i = 4'd2;
        bus.exp_i  = 4'd15;
        bus.mod_i  = 4'd13;
      end else begin
        bus.start = 1'b0;
      end
      @(posedge clk); #1;
      if (bus.done === 1'b1) begin
        dones++;
        if (first == 0) first = n + 1;
      end
    end
    bus.start = 1'b0;
    checks++;
    if (dones != 1 || first != ref_lat(4, 7)) begin
      errors++;
      $display("FAIL restart_ignored done_pulses=%0d first=%0d want 1 at %0d", dones, first, ref_lat(4, 7));
    end
    checks++;
    if (bus.key_o !== 4'd4) begin
      errors++;
      $display("FAIL restart_key got=%0d want=4", bus.key_o);
    end
    model_key = 4'd4;
  endtask

  task automatic test_reset_mid();
    int dones;
    run_key(4'd5, 4'd7, 4'd1, "pre_err");
    rst = 1'b0;
    #1;
    checks++;
    if (bus.err !== 1'b0 || bus.done !== 1'b0) begin
      errors++;
      $display("FAIL reset_clears_err err=%b done=%b want 0 0", bus.err, bus.done);
    end
    @(posedge clk); #1;
    rst = 1'b1;
    model_key = 4'd0;
    run_key(4'd3, 4'd4, 4'd7, "pre_key");
    bus.base_i = 4'd2;
    bus.exp_i  = 4'd15;
    bus.mod_i  = 4'd13;
    bus.start  = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    checks++;
    if (bus.key_o !== 4'd0 || bus.done !== 1'b0 || bus.busy !== 1'b0 || bus.err !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_outputs key=%0d done=%b busy=%b err=%b want all 0",
               bus.key_o, bus.done, bus.busy, bus.err);
    end
    dones = 0;
    for (int n = 0; n < 8; n++) begin
      @(posedge clk); #1;
      if (bus.done === 1'b1 || bus.busy === 1'b1) dones++;
    end
    checks++;
    if (dones != 0) begin
      errors++;
      $display("FAIL reset_mid_abort active_cycles=%0d want 0", dones);
    end
    model_key = 4'd0;
    rst = 1'b1;
    run_key(4'd5, 4'd3, 4'd11, "after_release");
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 150; i++) begin
      run_key(4'($urandom), 4'($urandom), 4'($urandom_range(0, 15)), "random");
    end
  endtask

  task automatic test_sweep();
    for (int m = 0; m < 16; m++)
      for (int b = 0; b < 16; b++)
        for (int e = 0; e < 16; e++)
          run_key(4'(b), 4'(e), 4'(m), "sweep");
  endtask

  initial begin
    test_reset();
    test_directed();
    test_restart_ignored();
    test_reset_mid();
    test_back_to_back();
    test_sweep();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/dh_key_gen.md
DH_KEY_GEN -- requirements
Module: dh_key_gen

Interface
REQ-001 SHALL have port clk  input  1  single clock; all state updates on posedge clk.
REQ-002 SHALL have port rst  input  1  asynchronous, active-low reset.
REQ-003 SHALL have port start  input  1  request a key computation; sampled in IDLE only.
REQ-004 SHALL have port base_i  input  4  generator or peer public value.
REQ-005 SHALL have port exp_i  input  4  private exponent.
REQ-006 SHALL have port mod_i  input  4  prime modulus p.
REQ-007 SHALL have port key_o  output  4  result base^exp mod p; this is the k_i consumed by the downstream challenge checker.
REQ-008 SHALL have port busy  output  1  high from the cycle after start is accepted until the cycle done is asserted.
REQ-009 SHALL have port done  output  1  single-cycle pulse; key_o is valid from this cycle.
REQ-010 SHALL have port err  output  1  set with done when mod_i < 2; held until the next accepted start.

Function
REQ-011 SHALL implement an FSM with states IDLE, CALC and FINISH.
REQ-012 IDLE with start=1 SHALL capture exp_i and mod_i, and SHALL capture base_i reduced modulo mod_i; it SHALL then set acc=1 and cnt=0, clear err, and go to CALC.
REQ-013 CALC SHALL process one exponent bit per cycle, LSB first (right-to-left square-and-multiply):
- if exp[cnt]=1, acc <= acc*b mod p;
- b <= b*b mod p;
- cnt <= cnt+1.
REQ-014 CALC SHALL run exactly 4 cycles (cnt 0..3) and then go to FINISH.
REQ-015 FINISH SHALL load key_o <= acc, pulse done for one cycle and return to IDLE; start is therefore accepted at cycle 0 and done is high at cycle 6.
REQ-016 key_o SHALL hold its value until the next FINISH.
REQ-017 All products SHALL be formed 8 bits wide and reduced to 4 bits with no truncation before reduction.
REQ-018 When mod_i is 0 or 1 at capture:
- the FSM SHALL skip CALC and go directly to FINISH;
- key_o SHALL be 0 and err SHALL be 1.
REQ-019 When exp_i=0, key_o SHALL equal 1 (for p >= 2).
REQ-020 start asserted while busy SHALL be ignored and SHALL NOT queue.
REQ-021 Input changes after capture SHALL NOT affect the computation in progress.

Reset
REQ-022 While rst=0:
- state=IDLE;
- key_o, done, busy and err SHALL all be 0;
- acc, b, exp, p and cnt SHALL be cleared.
REQ-023 Assertion of rst mid-computation SHALL abort the computation with no done pulse.
REQ-024 After rst is released, a start SHALL be accepted on the first clock edge.

Configuration
REQ-025 With macro DH_KEY_EARLY_EXIT_EN defined, CALC SHALL go to FINISH as soon as the remaining exponent bits (exp >> (cnt+1)) are zero, giving variable latency.
REQ-026 With DH_KEY_EARLY_EXIT_EN defined and exp_i=0, the FSM SHALL complete after 1 CALC cycle.
REQ-027 Without DH_KEY_EARLY_EXIT_EN, latency SHALL be fixed per REQ-014.
REQ-028 key_o SHALL be identical with and without DH_KEY_EARLY_EXIT_EN.

Structure
REQ-029 Shared package dh_pkg SHALL hold:
- KEY_W=4;
- CNT_W=2;
- the FSM state typedef;
- constant ONE=4'd1.
REQ-030 Sub-module dh_mod_mul SHALL be instantiated twice (multiply and square paths) and SHALL compute (a*b) mod m combinationally, returning 0 for m < 2.

Verification
REQ-031 Scenario: base=3, exp=4, p=7, start -> done at cycle 6, key_o=4, err=0.
REQ-032 Scenario: base=5, exp=3, p=11 -> key_o=4; then base=2, exp=15, p=13 -> key_o=8; base=14, exp=15, p=15 -> key_o=14.
REQ-033 Scenario: exp=0, p=7 -> key_o=1; mod=1 -> done at cycle 2, err=1, key_o=0.
REQ-034 Scenario: start re-pulsed at cycles 2 and 3 of a busy computation -> exactly one done pulse, result unchanged.
REQ-035 Scenario: rst=0 at cycle 3 of CALC -> no done pulse, all outputs 0; new start after release -> correct key.
REQ-036 Scenario (DH_KEY_EARLY_EXIT_EN defined): base=6, exp=1, p=7 -> key_o=6 with done at cycle 3; compare results against the non-macro build for all 4096 combinations of base, exp and p.
